// File: rtl/bram_stream_reader.sv
// Streams cmd_len bytes of BRAM words from cmd_addr (wrapping at DATA_DEPTH) out over AXI-Stream.
// Optional tkeep output is enabled by defining BRAM_READER_TKEEP_EN.
module bram_stream_reader #(
    parameter int DATA_WIDTH   = 64,
    parameter int DATA_DEPTH   = 2048,
    parameter int BRAM_LATENCY = 2,
    parameter int LEN_WIDTH    = 16,
    parameter int ADDR_WIDTH   = $clog2(DATA_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    output logic                    bram_en,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    input  logic [DATA_WIDTH-1:0]   bram_dout,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
`ifdef BRAM_READER_TKEEP_EN
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
`endif
    output logic                    busy
);
    localparam int BYTES       = DATA_WIDTH / 8;
    localparam int STORE_DEPTH = BRAM_LATENCY + 2;
    // The output register is the first storage slot; the skid buffer holds the rest.
    localparam int SKID_DEPTH  = STORE_DEPTH - 1;
    localparam int PTR_W       = $clog2(SKID_DEPTH);
    localparam int SKID_CW     = $clog2(SKID_DEPTH + 1);
    localparam int CNT_W       = $clog2(2 * STORE_DEPTH + 2);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_DRAIN = 2'd2} state_t;

    state_t                    state_r;
    logic                      cmd_ready_r, busy_r, bram_en_r, bram_last_r;
    logic [ADDR_WIDTH-1:0]     bram_addr_r, next_addr_r;
    logic [LEN_WIDTH:0]        reads_left_r, beats_s;
    logic [BRAM_LATENCY-1:0]   tag_valid_r, tag_last_r;
    logic [DATA_WIDTH-1:0]     skid_data_r [SKID_DEPTH];
    logic                      skid_last_r [SKID_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r, rd_ptr_r;
    logic [SKID_CW-1:0]        skid_cnt_r;
    logic                      out_valid_r, out_last_r;
    logic [DATA_WIDTH-1:0]     out_data_r;
    logic                      pop_s, cap_s, out_free_s, skid_pop_s, skid_push_s, load_cap_s, space_s;
    logic [CNT_W-1:0]          inflight_s, occ_s;
`ifdef BRAM_READER_TKEEP_EN
    logic [LEN_WIDTH-1:0]      rem_s;
    logic [BYTES-1:0]          keep_s, last_keep_r, out_keep_r;
`endif

    function automatic logic [ADDR_WIDTH-1:0] addr_inc_f(input logic [ADDR_WIDTH-1:0] a);
        if (a == ADDR_WIDTH'(DATA_DEPTH - 1)) addr_inc_f = {ADDR_WIDTH{1'b0}};
        else                                  addr_inc_f = a + ADDR_WIDTH'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc_f(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(SKID_DEPTH - 1)) ptr_inc_f = {PTR_W{1'b0}};
        else                             ptr_inc_f = p + PTR_W'(1);
    endfunction

    // Beat count, storage routing and the read-credit decision.
    always_comb begin
        beats_s     = ({1'b0, cmd_len} + (LEN_WIDTH+1)'(BYTES - 1)) / (LEN_WIDTH+1)'(BYTES);
        pop_s       = out_valid_r & m_axis_tready;
        cap_s       = tag_valid_r[BRAM_LATENCY-1];
        out_free_s  = ~out_valid_r | pop_s;
        skid_pop_s  = out_free_s & (skid_cnt_r != SKID_CW'(0));
        load_cap_s  = out_free_s & (skid_cnt_r == SKID_CW'(0)) & cap_s;
        skid_push_s = cap_s & ~load_cap_s;
        inflight_s  = CNT_W'(bram_en_r);
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            inflight_s = inflight_s + CNT_W'(tag_valid_r[i]);
        end
        occ_s   = CNT_W'(skid_cnt_r) + CNT_W'(out_valid_r);
        // The word leaving the output register this cycle frees its slot.
        space_s = (occ_s + inflight_s - CNT_W'(pop_s)) < CNT_W'(STORE_DEPTH);
    end

`ifdef BRAM_READER_TKEEP_EN
    // Byte enables for the final beat of the command being accepted.
    always_comb begin
        rem_s = cmd_len % LEN_WIDTH'(BYTES);
        for (int b = 0; b < BYTES; b++) begin
            keep_s[b] = (rem_s == LEN_WIDTH'(0)) || (LEN_WIDTH'(b) < rem_s);
        end
    end
`endif

    // Command FSM and BRAM read issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cmd_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            bram_en_r    <= 1'b0;
            bram_last_r  <= 1'b0;
            bram_addr_r  <= {ADDR_WIDTH{1'b0}};
            next_addr_r  <= {ADDR_WIDTH{1'b0}};
            reads_left_r <= {(LEN_WIDTH+1){1'b0}};
`ifdef BRAM_READER_TKEEP_EN
            last_keep_r  <= {BYTES{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    bram_en_r   <= 1'b0;
                    bram_last_r <= 1'b0;
                    if (cmd_valid && cmd_ready_r && (beats_s != (LEN_WIDTH+1)'(0))) begin
                        state_r      <= ST_READ;
                        cmd_ready_r  <= 1'b0;
                        busy_r       <= 1'b1;
                        bram_en_r    <= 1'b1;
                        bram_addr_r  <= cmd_addr;
                        bram_last_r  <= (beats_s == (LEN_WIDTH+1)'(1));
                        next_addr_r  <= addr_inc_f(cmd_addr);
                        reads_left_r <= beats_s - (LEN_WIDTH+1)'(1);
`ifdef BRAM_READER_TKEEP_EN
                        last_keep_r  <= keep_s;
`endif
                    end
                end
                ST_READ: begin
                    if (reads_left_r == (LEN_WIDTH+1)'(0)) begin
                        state_r     <= ST_DRAIN;
                        bram_en_r   <= 1'b0;
                        bram_last_r <= 1'b0;
                    end else if (space_s) begin
                        bram_en_r    <= 1'b1;
                        bram_addr_r  <= next_addr_r;
                        bram_last_r  <= (reads_left_r == (LEN_WIDTH+1)'(1));
                        next_addr_r  <= addr_inc_f(next_addr_r);
                        reads_left_r <= reads_left_r - (LEN_WIDTH+1)'(1);
                    end else begin
                        bram_en_r   <= 1'b0;
                        bram_last_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    bram_en_r   <= 1'b0;
                    bram_last_r <= 1'b0;
                    if ((occ_s == CNT_W'(0)) && (inflight_s == CNT_W'(0))) begin
                        state_r     <= ST_IDLE;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    bram_en_r   <= 1'b0;
                    bram_last_r <= 1'b0;
                end
            endcase
        end
    end

    // In-flight tags, skid buffer and AXI-Stream output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_r <= {BRAM_LATENCY{1'b0}};
            tag_last_r  <= {BRAM_LATENCY{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            skid_cnt_r  <= {SKID_CW{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
`ifdef BRAM_READER_TKEEP_EN
            out_keep_r  <= {BYTES{1'b0}};
`endif
        end else begin
            tag_valid_r[0] <= bram_en_r;
            tag_last_r[0]  <= bram_last_r;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_last_r[i]  <= tag_last_r[i-1];
            end
            if (skid_push_s) begin
                skid_data_r[wr_ptr_r] <= bram_dout;
                skid_last_r[wr_ptr_r] <= tag_last_r[BRAM_LATENCY-1];
                wr_ptr_r              <= ptr_inc_f(wr_ptr_r);
            end
            if (skid_pop_s) begin
                rd_ptr_r <= ptr_inc_f(rd_ptr_r);
            end
            case ({skid_push_s, skid_pop_s})
                2'b10:   skid_cnt_r <= skid_cnt_r + SKID_CW'(1);
                2'b01:   skid_cnt_r <= skid_cnt_r - SKID_CW'(1);
                default: skid_cnt_r <= skid_cnt_r;
            endcase
            if (skid_pop_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= skid_data_r[rd_ptr_r];
                out_last_r  <= skid_last_r[rd_ptr_r];
`ifdef BRAM_READER_TKEEP_EN
                out_keep_r  <= skid_last_r[rd_ptr_r] ? last_keep_r : {BYTES{1'b1}};
`endif
            end else if (load_cap_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= bram_dout;
                out_last_r  <= tag_last_r[BRAM_LATENCY-1];
`ifdef BRAM_READER_TKEEP_EN
                out_keep_r  <= tag_last_r[BRAM_LATENCY-1] ? last_keep_r : {BYTES{1'b1}};
`endif
            end else if (pop_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign cmd_ready     = cmd_ready_r;
    assign busy          = busy_r;
    assign bram_en       = bram_en_r;
    assign bram_addr     = bram_addr_r;
    assign m_axis_tvalid = out_valid_r;
    assign m_axis_tdata  = out_data_r;
    assign m_axis_tlast  = out_last_r;
`ifdef BRAM_READER_TKEEP_EN
    assign m_axis_tkeep  = out_keep_r;
`endif

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: BRAM word and stream beat width in bits, multiple of 8.
REQ-002 SHALL have parameter DATA_DEPTH, default 2048: BRAM depth in words.
REQ-003 SHALL have parameter BRAM_LATENCY, default 2: cycles from bram_en to valid bram_dout, range 1..4.
REQ-004 SHALL have parameter LEN_WIDTH, default 16: width of the command byte length.
REQ-005 SHALL have parameter ADDR_WIDTH, default $clog2(DATA_DEPTH): BRAM word address width.
REQ-006 SHALL use one clock and a synchronous, active-high reset: clk input 1 (sole clock), rst input 1 (synchronous, active-high).
REQ-007 SHALL have the following ports (name, direction, width, meaning):
- cmd_valid, input, 1: read command present.
- cmd_ready, output, 1: command accepted when both cmd_valid and cmd_ready are high.
- cmd_addr, input, ADDR_WIDTH: start word address.
- cmd_len, input, LEN_WIDTH: length in bytes.
- bram_en, output, 1: read enable to the BRAM read port.
- bram_addr, output, ADDR_WIDTH: BRAM read address.
- bram_dout, input, DATA_WIDTH: BRAM read data.
- m_axis_tdata, output, DATA_WIDTH: AXI-Stream data.
- m_axis_tvalid, output, 1: AXI-Stream valid.
- m_axis_tready, input, 1: AXI-Stream ready.
- m_axis_tlast, output, 1: final beat of the command.
- m_axis_tkeep, output, DATA_WIDTH/8: byte enables; present only when BRAM_READER_TKEEP_EN is defined.
- busy, output, 1: a command is in progress.

Function
REQ-008 SHALL implement states IDLE, READ and DRAIN. In IDLE, cmd_ready=1. A handshake moves IDLE->READ, or keeps IDLE when cmd_len=0. When the last read is issued, READ->DRAIN. When the FIFO is empty and nothing is in flight, DRAIN->IDLE.
REQ-009 SHALL compute beats = ceil(cmd_len / (DATA_WIDTH/8)).
REQ-010 SHALL accept a command with cmd_len=0, emit no beats, and keep cmd_ready high.
REQ-011 SHALL issue at most one read per cycle, at addresses cmd_addr+i modulo DATA_DEPTH for i = 0..beats-1; the address wraps from DATA_DEPTH-1 to 0.
REQ-012 SHALL hold bram_en=0 in IDLE and DRAIN.
REQ-013 SHALL track in-flight reads with a valid/last tag shift register of BRAM_LATENCY stages, capturing bram_dout exactly BRAM_LATENCY cycles after the matching bram_en.
REQ-014 SHALL buffer returned words in an internal FIFO of depth BRAM_LATENCY+2.
REQ-015 SHALL issue a read only when (FIFO occupancy + in-flight count) < FIFO depth, so the FIFO never overflows.
REQ-016 SHALL timing: handshake at edge N -> first bram_en in cycle N+1 -> first m_axis_tvalid in cycle N+2+BRAM_LATENCY.
REQ-017 SHALL sustain 1 beat/cycle while m_axis_tready=1.
REQ-018 SHALL follow AXI-Stream rules: once m_axis_tvalid is asserted, tdata/tlast/tkeep stay stable and tvalid stays high until the transfer completes.
REQ-019 SHALL assert m_axis_tlast only on beat beats-1.
REQ-020 SHALL handle a simultaneous FIFO push and pop in the same cycle with occupancy unchanged.
REQ-021 SHALL hold busy=1 in READ and DRAIN.
REQ-022 SHALL latch cmd_addr and cmd_len at the handshake, so later changes on those inputs are ignored.

Reset
REQ-023 SHALL, on rst=1 at an edge, clear the state to IDLE and set cmd_ready=1, bram_en=0, bram_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, busy=0.
REQ-024 SHALL, on reset, empty the FIFO and clear the in-flight tags, so BRAM data returning after reset is discarded.
REQ-025 SHALL give reset priority over command acceptance in the same cycle.

Configuration
REQ-026 SHALL, with macro BRAM_READER_TKEEP_EN defined, provide m_axis_tkeep: all ones on non-last beats; on the last beat, the low (cmd_len mod (DATA_WIDTH/8)) bits set, or all ones if that remainder is 0.
REQ-027 SHALL, without BRAM_READER_TKEEP_EN, omit the m_axis_tkeep port and related logic, with all other behaviour identical.

Verification (DATA_WIDTH=64, DATA_DEPTH=2048, BRAM_LATENCY=2, mem[i]=i)
REQ-028 SHALL cover: cmd_addr=0x010, cmd_len=32, tready=1 -> 4 consecutive beats 0x10..0x13, tlast on 0x13, first tvalid 4 cycles after handshake.
REQ-029 SHALL cover: cmd_addr=2046, cmd_len=32 -> beats 2046, 2047, 0, 1 in order.
REQ-030 SHALL cover: cmd_len=80, tready=0 for 10 cycles after the 2nd beat -> no loss or duplication, at most 4 reads outstanding, 10 beats total.
REQ-031 SHALL cover: cmd_len=0 -> no bram_en, no tvalid, cmd_ready stays 1.
REQ-032 SHALL cover, with BRAM_READER_TKEEP_EN: cmd_len=13 -> 2 beats, tkeep 0xFF then 0x1F, tlast on the 2nd.
REQ-033 SHALL cover: rst pulsed mid-command with 2 reads in flight -> tvalid=0 the next cycle, stale data never emitted, and a new command reads correctly.
